// File: rtl/uart_register_master_pkg.sv
// Shared definitions for the UART configuration register bus and its bus master.
//   - Register-file address map (*_ADDR), 3-bit bus addresses.
//   - FSR status bit indices used by the FIFO-polling macros.
//   - master_op_t: host command opcodes; encodings 5..7 are illegal.
//   - fsr_busy(): picks the FSR bit a poll macro waits on.
package uart_register_master_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] CTR_ADDR  = 3'd0;
    localparam logic [ADDR_W-1:0] LDVR_ADDR = 3'd1;
    localparam logic [ADDR_W-1:0] UDVR_ADDR = 3'd2;
    localparam logic [ADDR_W-1:0] FSR_ADDR  = 3'd3;
    localparam logic [ADDR_W-1:0] TXR_ADDR  = 3'd4;
    localparam logic [ADDR_W-1:0] RXR_ADDR  = 3'd5;

    // FSR: TX FIFO full and RX FIFO empty flags.
    localparam int unsigned FSR_TXF_BIT = 0;
    localparam int unsigned FSR_RXE_BIT = 1;

    typedef enum logic [2:0] {
        OpWrite    = 3'd0,
        OpRead     = 3'd1,
        OpSetDiv   = 3'd2,
        OpSendByte = 3'd3,
        OpRecvByte = 3'd4
    } master_op_t;

    // SEND_BYTE waits while the TX FIFO is full, RECV_BYTE while the RX FIFO is empty.
    function automatic logic fsr_busy(input logic [2:0] op, input logic [DATA_W-1:0] fsr);
        if (op == OpSendByte) begin
            return fsr[FSR_TXF_BIT];
        end
        return fsr[FSR_RXE_BIT];
    endfunction

endpackage

// File: rtl/uart_register_master.sv
// Bus initiator for the UART configuration register file. Converts one-shot host commands into
// single-cycle accesses on the 8-bit register bus.
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   cmd_valid_i  command request; accepted when cmd_valid_i & cmd_ready_o
//   cmd_ready_o  master idle
//   cmd_op_i     master_op_t opcode (5..7 illegal)
//   cmd_addr_i   register address for WRITE/READ
//   cmd_data_i   write data [7:0], divisor [15:0] for SET_DIV, TX byte [7:0] for SEND_BYTE
//   rsp_valid_o  one-cycle completion pulse
//   rsp_data_o   read data for READ/RECV_BYTE, else 0; held until the next response
//   rsp_error_o  poll timeout or illegal op, valid with rsp_valid_o
//   read_o       registered bus read strobe
//   write_o      registered bus write strobe
//   address_o    registered bus address
//   data_io      driven with write data while write_o=1, sampled while read_o=1
module uart_register_master
    import uart_register_master_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [15:0]       cmd_data_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_error_o,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] address_o,
    inout  wire  [DATA_W-1:0] data_io
);

    localparam int unsigned CntW = $clog2(POLL_LIMIT + 1);
    localparam logic [CntW-1:0] PollLimit = CntW'(POLL_LIMIT);

    typedef enum logic [3:0] {
        StIdle,
        StWr,
        StRd,
        StDivLo,
        StDivHi,
        StPoll,
        StXfer,
        StTxrHold,
        StResp
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [15:0]       data_q, data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [CntW-1:0]   cnt_inc;
    logic [DATA_W-1:0] bus_rdata;

    assign cnt_inc   = cnt_q + CntW'(1);
    assign bus_rdata = data_io;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            op_q       <= 3'd0;
            data_q     <= 16'd0;
            cnt_q      <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            read_q     <= read_d;
            write_q    <= write_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Bus strobes are flopped from the next state, so each access occupies exactly the
    // cycle spent in the corresponding state.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        address_d  = address_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    op_d   = cmd_op_i;
                    data_d = cmd_data_i;
                    cnt_d  = '0;
                    case (cmd_op_i)
                        OpWrite: begin
                            state_d   = StWr;
                            write_d   = 1'b1;
                            address_d = cmd_addr_i;
                            wdata_d   = cmd_data_i[7:0];
                        end
                        OpRead: begin
                            state_d   = StRd;
                            read_d    = 1'b1;
                            address_d = cmd_addr_i;
                        end
                        OpSetDiv: begin
                            state_d   = StDivLo;
                            write_d   = 1'b1;
                            address_d = LDVR_ADDR;
                            wdata_d   = cmd_data_i[7:0];
                        end
                        OpSendByte, OpRecvByte: begin
                            state_d   = StPoll;
                            read_d    = 1'b1;
                            address_d = FSR_ADDR;
                        end
                        default: begin
                            state_d    = StResp;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end

            StWr: begin
                state_d    = StResp;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end

            StRd: begin
                state_d    = StResp;
                rsp_data_d = bus_rdata;
                rsp_err_d  = 1'b0;
            end

            // UDVR must follow LDVR on the very next cycle for the divisor to commit.
            StDivLo: begin
                state_d   = StDivHi;
                write_d   = 1'b1;
                address_d = UDVR_ADDR;
                wdata_d   = data_q[15:8];
            end

            StDivHi: begin
                state_d    = StResp;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end

            StPoll: begin
                if (!fsr_busy(op_q, bus_rdata)) begin
                    state_d = StXfer;
                    if (op_q == OpSendByte) begin
                        write_d   = 1'b1;
                        address_d = TXR_ADDR;
                        wdata_d   = data_q[7:0];
                    end else begin
                        read_d    = 1'b1;
                        address_d = RXR_ADDR;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == PollLimit) begin
                        state_d    = StResp;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        read_d = 1'b1;
                    end
                end
            end

            StXfer: begin
                if (op_q == OpSendByte) begin
                    // Address held on TXR while the register file flops the push.
                    state_d = StTxrHold;
                end else begin
                    state_d    = StResp;
                    rsp_data_d = bus_rdata;
                    rsp_err_d  = 1'b0;
                end
            end

            StTxrHold: begin
                state_d    = StResp;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_error_o = rsp_err_q;
    assign read_o      = read_q;
    assign write_o     = write_q;
    assign address_o   = address_q;
    assign data_io     = write_q ? wdata_q : 'z;

endmodule
